// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared states, defaults and pricing helper for the vending controller
package vend_pkg;

    localparam int unsigned DEF_NUM_ITEMS   = 20;
    localparam int unsigned DEF_MAX_STOCK   = 10;
    localparam int unsigned DEF_COST_W      = 3;
    localparam int unsigned DEF_COST_STEP   = 4;
    localparam int unsigned DEF_TIMEOUT_CYC = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_CODE,
        S_CHECK,
        S_TRANSACT,
        S_VENDING
    } vend_state_e;

    // Price bands of `step` items each, clamped to the largest COST value.
    function automatic int unsigned vend_cost(input int unsigned idx,
                                              input int unsigned step,
                                              input int unsigned cost_w);
        int unsigned c;
        int unsigned c_max;
        c     = idx / step + 1;
        c_max = (1 << cost_w) - 1;
        return (c > c_max) ? c_max : c;
    endfunction

endpackage

// File: rtl/vend_inventory.sv
// rtl/vend_inventory.sv - per-item stock counters with reload, guarded decrement and combinational read
module vend_inventory #(
    parameter int unsigned NUM_ITEMS = 20,
    parameter int unsigned MAX_STOCK = 10,
    parameter int unsigned STOCK_W   = 4,
    parameter int unsigned IDX_W     = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reload,
    input  logic               dec,
    input  logic [IDX_W-1:0]   dec_idx,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [STOCK_W-1:0] rd_data
);

    logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0] stock_d [NUM_ITEMS];

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_d[i] = stock_q[i];
            if (reload) begin
                stock_d[i] = STOCK_W'(MAX_STOCK);
            end else if (dec && dec_idx == IDX_W'(i) && stock_q[i] != '0) begin
                stock_d[i] = stock_q[i] - STOCK_W'(1);
            end
        end
    end

    // Out-of-range codes read as empty so the caller sees them as unsellable.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = stock_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= '0;
            end
        end else begin
            stock_q <= stock_d;
        end
    end

endmodule

// File: rtl/vending_machine_multi.sv
// rtl/vending_machine_multi.sv - card/keypad/door vending FSM; VEND_SALES_CNT_EN adds SALES_TOTAL
module vending_machine_multi
    import vend_pkg::*;
#(
    parameter int unsigned NUM_ITEMS   = DEF_NUM_ITEMS,
    parameter int unsigned MAX_STOCK   = DEF_MAX_STOCK,
    parameter int unsigned COST_W      = DEF_COST_W,
    parameter int unsigned COST_STEP   = DEF_COST_STEP,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RELOAD,
    input  logic              CARD_IN,
    input  logic [3:0]        ITEM_CODE,
    input  logic              KEY_PRESS,
    input  logic              VALID_TRAN,
    input  logic              DOOR_OPEN,
    output logic              VEND,
    output logic              INVALID_SEL,
    output logic [COST_W-1:0] COST,
    output logic              FAILED_TRAN
`ifdef VEND_SALES_CNT_EN
    ,
    output logic [15:0]       SALES_TOTAL
`endif
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned STOCK_W = $clog2(MAX_STOCK + 1);

    vend_state_e         state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [3:0]          tens_q, tens_d, units_q, units_d;
    logic                have_tens_q, have_tens_d;
    logic                opened_q, opened_d;
    logic                vend_q, vend_d, invalid_q, invalid_d, failed_q, failed_d;
    logic [COST_W-1:0]   cost_q, cost_d;
`ifdef VEND_SALES_CNT_EN
    logic [15:0]         sales_q, sales_d;
    logic [16:0]         sales_sum;
`endif

    logic [6:0]          idx;
    logic [STOCK_W-1:0]  stock_rd;
    logic                timeout;
    logic                accept;

    assign idx     = 7'(tens_q) * 7'd10 + 7'(units_q);
    assign timeout = (timer_q == TIMER_W'(TIMEOUT_CYC));
    assign accept  = (state_q == S_TRANSACT) && CARD_IN && VALID_TRAN;

    vend_inventory #(
        .NUM_ITEMS (NUM_ITEMS),
        .MAX_STOCK (MAX_STOCK),
        .STOCK_W   (STOCK_W),
        .IDX_W     (7)
    ) u_inv (
        .clk     (CLK),
        .rst     (RESET),
        .reload  ((state_q == S_IDLE) && RELOAD),
        .dec     (accept),
        .dec_idx (idx),
        .rd_idx  (idx),
        .rd_data (stock_rd)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timeout ? timer_q : timer_q + TIMER_W'(1);
        tens_d      = tens_q;
        units_d     = units_q;
        have_tens_d = have_tens_q;
        opened_d    = opened_q;
        vend_d      = vend_q;
        invalid_d   = invalid_q;
        failed_d    = failed_q;
        cost_d      = cost_q;
`ifdef VEND_SALES_CNT_EN
        sales_sum   = {1'b0, sales_q} + 17'(cost_q);
        sales_d     = sales_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!RELOAD && CARD_IN) begin
                    state_d     = S_GET_CODE;
                    have_tens_d = 1'b0;
                    opened_d    = 1'b0;
                end else if (!RELOAD) begin
                    vend_d    = 1'b0;
                    invalid_d = 1'b0;
                    failed_d  = 1'b0;
                    cost_d    = '0;
                end
            end
            S_GET_CODE: begin
                if (!CARD_IN) begin
                    state_d = S_IDLE;
                end else if (KEY_PRESS) begin
                    timer_d = '0;
                    if (!have_tens_q) begin
                        tens_d      = ITEM_CODE;
                        have_tens_d = 1'b1;
                    end else begin
                        units_d = ITEM_CODE;
                        state_d = S_CHECK;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (!CARD_IN) begin
                    state_d = S_IDLE;
                end else if (tens_q > 4'd9 || units_q > 4'd9 ||
                             idx >= 7'(NUM_ITEMS) || stock_rd == '0) begin
                    invalid_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cost_d  = COST_W'(vend_cost(32'(idx), COST_STEP, COST_W));
                    state_d = S_TRANSACT;
                end
            end
            S_TRANSACT: begin
                if (!CARD_IN) begin
                    state_d = S_IDLE;
                end else if (VALID_TRAN) begin
                    vend_d  = 1'b1;
                    state_d = S_VENDING;
`ifdef VEND_SALES_CNT_EN
                    sales_d = sales_sum[16] ? 16'hFFFF : sales_sum[15:0];
`endif
                end else if (timeout) begin
                    failed_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_VENDING: begin
                // Card state is irrelevant here: the item is already committed.
                if (opened_q) begin
                    if (!DOOR_OPEN) state_d = S_IDLE;
                end else if (DOOR_OPEN) begin
                    opened_d = 1'b1;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) timer_d = '0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            tens_q      <= '0;
            units_q     <= '0;
            have_tens_q <= 1'b0;
            opened_q    <= 1'b0;
            vend_q      <= 1'b0;
            invalid_q   <= 1'b0;
            failed_q    <= 1'b0;
            cost_q      <= '0;
`ifdef VEND_SALES_CNT_EN
            sales_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            tens_q      <= tens_d;
            units_q     <= units_d;
            have_tens_q <= have_tens_d;
            opened_q    <= opened_d;
            vend_q      <= vend_d;
            invalid_q   <= invalid_d;
            failed_q    <= failed_d;
            cost_q      <= cost_d;
`ifdef VEND_SALES_CNT_EN
            sales_q     <= sales_d;
`endif
        end
    end

    assign VEND        = vend_q;
    assign INVALID_SEL = invalid_q;
    assign FAILED_TRAN = failed_q;
    assign COST        = cost_q;
`ifdef VEND_SALES_CNT_EN
    assign SALES_TOTAL = sales_q;
`endif

endmodule
